mem_ctrl: RTL and testbench

Memory-side responder for the CPU's two cache ports. It accepts packed read and write requests from the data cache (port 0) and the instruction cache (port 1), arbitrates between them round-robin, and serialises each 32-bit word access into four byte accesses on a single-port, byte-wide synchronous RAM. It sits between `cpu` and the RAM model in the top-level and SoC benches, and answers every request with a `busy`/`done` handshake.

---
 rtl/mem_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Two-port round-robin memory responder: serialises 32-bit word reads/writes
// from the data and instruction cache ports into four byte accesses on a byte-wide RAM.
module mem_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int RAM_ADDR_W = 17
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              mem_rw_flag_i,
   input  logic [2*ADDR_W-1:0]     mem_addr_i,
   input  logic [63:0]             mem_w_data_i,
   input  logic [7:0]              mem_w_mask_i,
   output logic [63:0]             mem_r_data_o,
   output logic [1:0]              mem_busy_o,
   output logic [1:0]              mem_done_o,
   output logic [RAM_ADDR_W-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [7:0]              ram_wdata_o,
   input  logic [7:0]              ram_rdata_i
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t                  state_reg;
   logic                    gnt_reg;
   logic                    last_reg;
   logic [2:0]              k_reg;
   logic [RAM_ADDR_W-3:0]   word_reg;
   logic [31:0]             wdata_reg;
   logic [3:0]              mask_reg;
   logic [23:0]             rasm_reg;

   logic [1:0]              req_valid;
   logic [1:0]              req_read;
   logic                    sel;
   logic [ADDR_W-1:0]       sel_addr;
   logic [31:0]             sel_data;
   logic [3:0]              sel_mask;
   logic [2:0]              k_inc;
   logic                    unused_addr_bits;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         // 01 and 10 are the only legal flags; 00 and 11 are both idle.
         assign req_valid[gi]  = ^mem_rw_flag_i[2*gi+1 -: 2];
         assign req_read[gi]   = (mem_rw_flag_i[2*gi+1 -: 2] == 2'b01);
         assign mem_busy_o[gi] = (state_reg != IDLE) && (gnt_reg == 1'(gi));
      end
   endgenerate

   // Port 1 wins when it is alone, or when both request and port 0 went last.
   assign sel      = req_valid[1] & (~req_valid[0] | ~last_reg);
   assign sel_addr = sel ? mem_addr_i[2*ADDR_W-1:ADDR_W] : mem_addr_i[ADDR_W-1:0];
   assign sel_data = sel ? mem_w_data_i[63:32] : mem_w_data_i[31:0];
   assign sel_mask = sel ? mem_w_mask_i[7:4] : mem_w_mask_i[3:0];
   assign k_inc    = k_reg + 3'd1;

   assign unused_addr_bits = ^{sel_addr[ADDR_W-1:RAM_ADDR_W], sel_addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         gnt_reg      <= 1'b0;
         last_reg     <= 1'b1;
         k_reg        <= 3'd0;
         word_reg     <= '0;
         wdata_reg    <= '0;
         mask_reg     <= '0;
         rasm_reg     <= '0;
         mem_r_data_o <= '0;
         mem_done_o   <= '0;
         ram_addr_o   <= '0;
         ram_we_o     <= 1'b0;
         ram_wdata_o  <= '0;
      end else begin
         mem_done_o <= '0;
         ram_we_o   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|req_valid) begin
                  gnt_reg     <= sel;
                  last_reg    <= sel;
                  word_reg    <= sel_addr[RAM_ADDR_W-1:2];
                  wdata_reg   <= sel_data;
                  mask_reg    <= sel_mask;
                  k_reg       <= 3'd0;
                  ram_addr_o  <= {sel_addr[RAM_ADDR_W-1:2], 2'b00};
                  ram_wdata_o <= sel_data[7:0];
                  ram_we_o    <= ~req_read[sel] & sel_mask[0];
                  state_reg   <= req_read[sel] ? RD : WR;
               end
            end
            RD: begin
               k_reg <= k_inc;
               // RAM data lags the address by one cycle, so step k captures byte k-1.
               case (k_reg)
                  3'd1:    rasm_reg[7:0]   <= ram_rdata_i;
                  3'd2:    rasm_reg[15:8]  <= ram_rdata_i;
                  3'd3:    rasm_reg[23:16] <= ram_rdata_i;
                  default: ;
               endcase
               if (k_reg < 3'd3)
                  ram_addr_o <= {word_reg, k_inc[1:0]};
               if (k_reg == 3'd4) begin
                  if (gnt_reg)
                     mem_r_data_o[63:32] <= {ram_rdata_i, rasm_reg};
                  else
                     mem_r_data_o[31:0]  <= {ram_rdata_i, rasm_reg};
                  mem_done_o[gnt_reg] <= 1'b1;
                  state_reg           <= DONE;
               end
            end
            WR: begin
               k_reg <= k_inc;
               if (k_reg == 3'd3) begin
                  mem_done_o[gnt_reg] <= 1'b1;
                  state_reg           <= DONE;
               end else begin
                  ram_addr_o  <= {word_reg, k_inc[1:0]};
                  ram_wdata_o <= wdata_reg[{k_inc[1:0], 3'b000} +: 8];
                  ram_we_o    <= mask_reg[k_inc[1:0]];
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model with one-cycle read latency,
// linear stimulus with hand-computed expectations checked by immediate assertions.
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  flag;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [7:0]  mask;
   logic [63:0] r_data;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [16:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   logic        bd_clr;
   logic        bd_we;
   logic [16:0] bd_addr;
   logic [7:0]  bd_data;
   logic [7:0]  ram_mem [0:131071];

   int checks;
   int errors;

   mem_ctrl #(.ADDR_W(32), .RAM_ADDR_W(17)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_rw_flag_i(flag),
      .mem_addr_i   (addr),
      .mem_w_data_i (wdata),
      .mem_w_mask_i (mask),
      .mem_r_data_o (r_data),
      .mem_busy_o   (busy),
      .mem_done_o   (done),
      .ram_addr_o   (ram_addr),
      .ram_we_o     (ram_we),
      .ram_wdata_o  (ram_wdata),
      .ram_rdata_i  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous byte RAM; the backdoor port is only used while the DUT is idle.
   always @(posedge clk) begin
      if (bd_clr) begin
         for (int i = 0; i < 131072; i++) ram_mem[i] <= 8'h00;
      end else if (bd_we) begin
         ram_mem[bd_addr] <= bd_data;
      end else if (ram_we) begin
         ram_mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= ram_mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic poke(input logic [16:0] a, input logic [7:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      tick();
      bd_we   = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] wr_bytes [4];
   logic       wr_we    [4];

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; flag = '0; addr = '0; wdata = '0; mask = '0;
      bd_clr = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      wr_bytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      wr_we    = '{1'b1, 1'b0, 1'b1, 1'b0};
      tick();
      bd_clr = 1'b0;
      tick();
      chk("rst_busy", busy, 2'b00);
      chk("rst_done", done, 2'b00);
      chk("rst_rdata", r_data, 64'h0);
      chk("rst_ram_addr", ram_addr, 17'h0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_wdata", ram_wdata, 8'h00);
      rst = 1'b0;
      tick();

      // Read on port 0 from an unaligned address
      poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
      flag = 4'b0001; addr[31:0] = 32'h102;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rd0_addr", ram_addr, 17'h100 + i);
         chk("rd0_we", ram_we, 1'b0);
         chk("rd0_busy", busy, 2'b01);
      end
      tick();
      chk("rd0_done_early", done, 2'b00);
      tick();
      chk("rd0_done", done, 2'b01);
      chk("rd0_data", r_data[31:0], 32'h44332211);
      chk("rd0_busy_done", busy, 2'b01);
      flag = 4'b0000;
      tick();
      chk("rd0_busy_after", busy, 2'b00);
      chk("rd0_done_after", done, 2'b00);
      $display("read  p0 addr=0x102 data=%h", r_data[31:0]);

      // Masked write on port 1
      flag = 4'b1000; addr[63:32] = 32'h200; wdata[63:32] = 32'hAABBCCDD; mask[7:4] = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wr1_addr", ram_addr, 17'h200 + i);
         chk("wr1_we", ram_we, wr_we[i]);
         chk("wr1_wdata", ram_wdata, wr_bytes[i]);
         chk("wr1_busy", busy, 2'b10);
      end
      tick();
      chk("wr1_done", done, 2'b10);
      chk("wr1_we_done", ram_we, 1'b0);
      flag = 4'b0000;
      tick();
      chk("wr1_busy_after", busy, 2'b00);
      chk("wr1_ram0", ram_mem[17'h200], 8'hDD);
      chk("wr1_ram1", ram_mem[17'h201], 8'h00);
      chk("wr1_ram2", ram_mem[17'h202], 8'hBB);
      chk("wr1_ram3", ram_mem[17'h203], 8'h00);
      $display("write p1 addr=0x200 mask=0101");

      flag = 4'b0100;
      for (int i = 0; i < 5; i++) tick();
      chk("rd1_done_early", done, 2'b00);
      tick();
      chk("rd1_done", done, 2'b10);
      chk("rd1_data", r_data[63:32], 32'h00BB00DD);
      chk("rd1_p0_kept", r_data[31:0], 32'h44332211);
      flag = 4'b0000;
      tick();
      $display("read  p1 addr=0x200 data=%h", r_data[63:32]);

      // Simultaneous reads, then port 0 re-raises while port 1 still waits
      poke(17'h300, 8'h01); poke(17'h301, 8'h02); poke(17'h302, 8'h03); poke(17'h303, 8'h04);
      poke(17'h400, 8'hA1); poke(17'h401, 8'hA2); poke(17'h402, 8'hA3); poke(17'h403, 8'hA4);
      flag = 4'b0101; addr = {32'h400, 32'h300};
      tick();
      chk("tie_first_busy", busy, 2'b01);
      chk("tie_first_addr", ram_addr, 17'h300);
      for (int i = 0; i < 4; i++) tick();
      chk("tie_loser_idle", busy, 2'b01);
      tick();
      chk("tie_first_done", done, 2'b01);
      chk("tie_first_data", r_data[31:0], 32'h04030201);
      $display("read  p0 addr=0x300 data=%h (tie)", r_data[31:0]);
      tick();
      chk("tie_bubble_busy", busy, 2'b00);
      tick();
      chk("tie_second_busy", busy, 2'b10);
      chk("tie_second_addr", ram_addr, 17'h400);
      for (int i = 0; i < 4; i++) tick();
      tick();
      chk("tie_second_done", done, 2'b10);
      chk("tie_second_data", r_data[63:32], 32'hA4A3A2A1);
      $display("read  p1 addr=0x400 data=%h (tie)", r_data[63:32]);
      flag = 4'b0001;
      tick();
      chk("tie_third_idle", busy, 2'b00);
      tick();
      chk("tie_third_busy", busy, 2'b01);
      for (int i = 0; i < 4; i++) tick();
      tick();
      chk("tie_third_done", done, 2'b01);
      flag = 4'b0000;
      tick();
      $display("read  p0 addr=0x300 data=%h", r_data[31:0]);

      // Illegal flag 11 on port 0
      flag = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ill_busy", busy, 2'b00);
         chk("ill_we", ram_we, 1'b0);
         chk("ill_done", done, 2'b00);
      end
      chk("ill_addr", ram_addr, 17'h303);
      flag = 4'b0000;
      $display("idle  p0 flag=11 ignored");

      // Reset in the middle of a write
      flag = 4'b0010; addr[31:0] = 32'h500; wdata[31:0] = 32'h44332211; mask[3:0] = 4'b1111;
      tick();
      chk("rw_addr0", ram_addr, 17'h500);
      chk("rw_we0", ram_we, 1'b1);
      tick();
      tick();
      chk("rw_addr2", ram_addr, 17'h502);
      chk("rw_wdata2", ram_wdata, 8'h33);
      rst = 1'b1; flag = 4'b0000;
      tick();
      chk("rw_we_rst", ram_we, 1'b0);
      chk("rw_busy_rst", busy, 2'b00);
      chk("rw_done_rst", done, 2'b00);
      chk("rw_rdata_rst", r_data, 64'h0);
      rst = 1'b0;
      tick();
      tick();
      chk("rw_we_after", ram_we, 1'b0);
      chk("rw_done_after", done, 2'b00);
      chk("rw_ram2", ram_mem[17'h502], 8'h33);
      chk("rw_ram3", ram_mem[17'h503], 8'h00);
      $display("write p0 addr=0x500 aborted by reset");
      flag = 4'b0001;
      for (int i = 0; i < 5; i++) tick();
      tick();
      chk("rw_read_done", done, 2'b01);
      chk("rw_read_data", r_data[31:0], 32'h00332211);
      flag = 4'b0000;
      tick();
      $display("read  p0 addr=0x500 data=%h", r_data[31:0]);

      // Write with flag dropped at done, then a write with the flag held
      flag = 4'b0010; addr[31:0] = 32'h600; wdata[31:0] = 32'h0A0B0C0D; mask[3:0] = 4'b1111;
      for (int i = 0; i < 4; i++) tick();
      tick();
      chk("wa_done", done, 2'b01);
      flag = 4'b0000;
      tick();
      chk("wa_idle_busy", busy, 2'b00);
      tick();
      chk("wa_no_dup_busy", busy, 2'b00);
      chk("wa_no_dup_done", done, 2'b00);
      chk("wa_ram3", ram_mem[17'h603], 8'h0A);
      $display("write p0 addr=0x600 data=0a0b0c0d");

      flag = 4'b0010; addr[31:0] = 32'h604; wdata[31:0] = 32'h11223344;
      for (int i = 0; i < 4; i++) tick();
      tick();
      chk("wb_done", done, 2'b01);
      tick();
      chk("wb_bubble_busy", busy, 2'b00);
      chk("wb_bubble_done", done, 2'b00);
      tick();
      chk("wb_again_busy", busy, 2'b01);
      chk("wb_again_addr", ram_addr, 17'h604);
      chk("wb_again_we", ram_we, 1'b1);
      flag = 4'b0000;
      for (int i = 0; i < 3; i++) tick();
      tick();
      chk("wb_again_done", done, 2'b01);
      tick();
      chk("wb_ram0", ram_mem[17'h604], 8'h44);
      $display("write p0 addr=0x604 held flag, repeated once");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
